// File: rtl/seg_scan_counter.sv
// seg_scan_counter: N-digit decimal/hex up/down counter with prescaler and a muxed 7-segment scan driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module seg_scan_counter #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned PRESCALE_W = 20,
  parameter int unsigned SCAN_W     = 10,
  parameter int unsigned HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PRESCALE_W-1:0]   tick_div,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  input  logic                    pause,
  output logic [4*N_DIGITS-1:0]   count,
  output logic                    wrap,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     digit_sel
);

  localparam int unsigned CW        = 4 * N_DIGITS;
  localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [3:0]  DIGIT_MAX = (HEX_MODE != 0) ? 4'hF : 4'h9;

  logic [PRESCALE_W-1:0] presc;
  logic [SCAN_W-1:0]     scan_div;
  logic [IDX_W-1:0]      idx;

  logic [CW-1:0]         count_step;
  logic [CW-1:0]         load_fix;
  logic                  roll;
  logic                  step_carry;
  logic [3:0]            step_d;
  logic [3:0]            load_d;
  logic                  tick;

  logic                  scan_wrap;
  logic [IDX_W-1:0]      idx_next;
  logic [3:0]            sel_d;
  logic [N_DIGITS-1:0]   sel_onehot;
  logic                  blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0]      msd;
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0:    seg_code = 7'h3F;
      4'h1:    seg_code = 7'h06;
      4'h2:    seg_code = 7'h5B;
      4'h3:    seg_code = 7'h4F;
      4'h4:    seg_code = 7'h66;
      4'h5:    seg_code = 7'h6D;
      4'h6:    seg_code = 7'h7D;
      4'h7:    seg_code = 7'h07;
      4'h8:    seg_code = 7'h7F;
      4'h9:    seg_code = 7'h6F;
      4'hA:    seg_code = 7'h77;
      4'hB:    seg_code = 7'h7C;
      4'hC:    seg_code = 7'h39;
      4'hD:    seg_code = 7'h5E;
      4'hE:    seg_code = 7'h79;
      default: seg_code = 7'h71;
    endcase
  endfunction

  assign tick = (presc >= tick_div);

  // Ripple step: step_carry stays high while every lower digit rolled over; its final value is the wrap.
  always_comb begin
    count_step = count;
    step_carry = 1'b1;
    step_d     = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      step_d = count[4*i +: 4];
      if (step_carry) begin
        if (up_down) begin
          step_carry = (step_d == DIGIT_MAX);
          count_step[4*i +: 4] = step_carry ? 4'h0 : step_d + 4'd1;
        end else begin
          step_carry = (step_d == 4'h0);
          count_step[4*i +: 4] = step_carry ? DIGIT_MAX : step_d - 4'd1;
        end
      end
    end
    roll = step_carry;
  end

  always_comb begin
    load_fix = load_val;
    load_d   = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      load_d = load_val[4*i +: 4];
      if (load_d > DIGIT_MAX) load_fix[4*i +: 4] = DIGIT_MAX;
    end
  end

  always_comb begin
    scan_wrap = (scan_div == '1);
    idx_next  = idx;
    if (scan_wrap) idx_next = (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    sel_d      = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      sel_onehot[i] = (idx_next == IDX_W'(i));
      if (idx_next == IDX_W'(i)) sel_d = count[4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (count[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
    blank = (idx_next > msd);
`else
    blank = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      presc     <= '0;
      scan_div  <= '0;
      idx       <= '0;
      digit_sel <= N_DIGITS'(1);
      segments  <= 7'h3F;
      dp        <= 1'b0;
      wrap      <= 1'b0;
    end else if (ena) begin
      scan_div  <= scan_div + SCAN_W'(1);
      idx       <= idx_next;
      digit_sel <= sel_onehot;
      segments  <= blank ? 7'h00 : seg_code(sel_d);
      dp        <= pause && (idx_next == '0);
      if (load) begin
        count <= load_fix;
        presc <= '0;
        wrap  <= 1'b0;
      end else begin
        presc <= tick ? '0 : presc + PRESCALE_W'(1);
        if (tick && !pause) begin
          count <= count_step;
          wrap  <= roll;
        end else begin
          wrap  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Bench for seg_scan_counter: a decimal and a hex instance checked against a per-cycle reference model.
// Honours LEADING_ZERO_BLANK_EN in the model so the same bench covers both builds.
module tb_seg_scan_counter;

  localparam int unsigned ND = 4;
  localparam int unsigned PW = 20;
  localparam int unsigned SW = 2;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          rst, ena, up_down, load, pause;
  logic [PW-1:0] tick_div;
  logic [15:0]   load_val;
  logic [15:0]   count, h_count;
  logic          wrap, h_wrap, dp, h_dp;
  logic [6:0]    segments, h_segments;
  logic [3:0]    digit_sel, h_digit_sel;

  typedef struct {
    logic [15:0] count;
    logic        wrap;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] hcount;
    logic        hwrap;
    logic [6:0]  hseg;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  int   m_val, m_hval, m_presc, m_scan, m_idx;
  logic m_wrap, m_hwrap, m_dp;
  logic [3:0] m_sel;
  logic [6:0] m_seg, m_hseg;

  seg_scan_counter #(.N_DIGITS(ND), .PRESCALE_W(PW), .SCAN_W(SW), .HEX_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .tick_div(tick_div), .up_down(up_down), .load(load),
    .load_val(load_val), .pause(pause), .count(count), .wrap(wrap), .segments(segments),
    .dp(dp), .digit_sel(digit_sel)
  );

  seg_scan_counter #(.N_DIGITS(ND), .PRESCALE_W(PW), .SCAN_W(SW), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .ena(ena), .tick_div(tick_div), .up_down(up_down), .load(load),
    .load_val(load_val), .pause(pause), .count(h_count), .wrap(h_wrap), .segments(h_segments),
    .dp(h_dp), .digit_sel(h_digit_sel)
  );

  always #5 clk = ~clk;

  function automatic int digit_of(int v, int base, int i);
    int x = v;
    for (int k = 0; k < i; k++) x = x / base;
    return x % base;
  endfunction

  function automatic logic [6:0] disp(int v, int base, int i);
`ifdef LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int k = 0; k < 4; k++) if (digit_of(v, base, k) != 0) msd = k;
    if (i > msd) return 7'h00;
`endif
    return SEG_TAB[digit_of(v, base, i)];
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'(digit_of(v, 10, k));
    return r;
  endfunction

  function automatic int dec_load(logic [15:0] lv);
    int v = 0;
    int mult = 1;
    int d;
    for (int k = 0; k < 4; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      v = v + d * mult;
      mult = mult * 10;
    end
    return v;
  endfunction

  // Reference model: integer arithmetic, one expected entry pushed per clock edge.
  always @(posedge clk) begin
    exp_t n;
    logic tk;
    if (rst) begin
      m_val = 0; m_hval = 0; m_presc = 0; m_scan = 0; m_idx = 0;
      m_wrap = 1'b0; m_hwrap = 1'b0; m_sel = 4'b0001; m_seg = 7'h3F; m_hseg = 7'h3F; m_dp = 1'b0;
    end else if (ena) begin
      if (m_scan == (1 << SW) - 1) m_idx = (m_idx + 1) % ND;
      m_scan = (m_scan + 1) % (1 << SW);
      m_sel  = 4'(1 << m_idx);
      m_seg  = disp(m_val, 10, m_idx);
      m_hseg = disp(m_hval, 16, m_idx);
      m_dp   = pause && (m_idx == 0);
      if (load) begin
        m_val = dec_load(load_val); m_hval = int'(load_val);
        m_presc = 0; m_wrap = 1'b0; m_hwrap = 1'b0;
      end else begin
        tk = (m_presc >= int'(tick_div));
        m_presc = tk ? 0 : m_presc + 1;
        m_wrap = 1'b0; m_hwrap = 1'b0;
        if (tk && !pause) begin
          if (up_down) begin
            m_wrap  = (m_val == 9999);  m_val  = (m_val + 1) % 10000;
            m_hwrap = (m_hval == 65535); m_hval = (m_hval + 1) % 65536;
          end else begin
            m_wrap  = (m_val == 0);  m_val  = (m_val + 9999) % 10000;
            m_hwrap = (m_hval == 0); m_hval = (m_hval + 65535) % 65536;
          end
        end
      end
    end
    n.count = to_bcd(m_val); n.wrap = m_wrap; n.sel = m_sel; n.seg = m_seg; n.dp = m_dp;
    n.hcount = 16'(m_hval); n.hwrap = m_hwrap; n.hseg = m_hseg;
    sb.push_back(n);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: no expected entry at time %0t", $time);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; tick_div = '0; up_down = 1'b1; load = 1'b0; load_val = '0; pause = 1'b0;
    step();
    step();
    total++; if (count !== 16'h0000) begin bad++; $display("FAIL reset count act=%h req=0000", count); end
    total++; if (digit_sel !== 4'b0001) begin bad++; $display("FAIL reset digit_sel act=%b req=0001", digit_sel); end
    total++; if (segments !== 7'h3F) begin bad++; $display("FAIL reset segments act=%h req=3F", segments); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset wrap act=%b req=0", wrap); end
    total++; if (dp !== 1'b0) begin bad++; $display("FAIL reset dp act=%b req=0", dp); end
    total++; if (h_count !== 16'h0000) begin bad++; $display("FAIL reset h_count act=%h req=0000", h_count); end
    rst = 1'b0;
  endtask

  task automatic test_decimal_carry();
    logic [15:0] want [3];
    want[0] = 16'h0998; want[1] = 16'h0999; want[2] = 16'h1000;
    tick_div = '0; up_down = 1'b1; pause = 1'b0; load = 1'b1; load_val = 16'h0998;
    for (int k = 0; k < 3; k++) begin
      step();
      load = 1'b0;
      total++; if (count !== want[k]) begin bad++; $display("FAIL carry count[%0d] act=%h req=%h", k, count, want[k]); end
      total++; if (count !== e.count) begin bad++; $display("FAIL carry model[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL carry wrap[%0d] act=%b req=%b", k, wrap, e.wrap); end
    end
  endtask

  task automatic test_up_wrap();
    up_down = 1'b1; tick_div = '0; load = 1'b1; load_val = 16'h9999;
    step();
    load = 1'b0;
    total++; if (count !== 16'h9999) begin bad++; $display("FAIL upwrap load act=%h req=9999", count); end
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL upwrap count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL upwrap wrap[%0d] act=%b req=%b", k, wrap, e.wrap); end
      total++; if (h_count !== e.hcount) begin bad++; $display("FAIL upwrap h_count[%0d] act=%h req=%h", k, h_count, e.hcount); end
      total++; if (h_wrap !== e.hwrap) begin bad++; $display("FAIL upwrap h_wrap[%0d] act=%b req=%b", k, h_wrap, e.hwrap); end
    end
    load = 1'b1; load_val = 16'h00AB;
    step();
    load = 1'b0;
    total++; if (count !== 16'h0099) begin bad++; $display("FAIL clamp count act=%h req=0099", count); end
    total++; if (h_count !== 16'h00AB) begin bad++; $display("FAIL clamp h_count act=%h req=00AB", h_count); end
  endtask

  task automatic test_down_wrap();
    up_down = 1'b0; tick_div = '0; load = 1'b1; load_val = 16'h0000;
    step();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL downwrap count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL downwrap wrap[%0d] act=%b req=%b", k, wrap, e.wrap); end
      total++; if (h_count !== e.hcount) begin bad++; $display("FAIL downwrap h_count[%0d] act=%h req=%h", k, h_count, e.hcount); end
      total++; if (h_wrap !== e.hwrap) begin bad++; $display("FAIL downwrap h_wrap[%0d] act=%b req=%b", k, h_wrap, e.hwrap); end
    end
    up_down = 1'b1;
  endtask

  task automatic test_prescaler_pause();
    tick_div = PW'(3); up_down = 1'b1; pause = 1'b0; load = 1'b1; load_val = 16'h0000;
    step();
    load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL presc count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL presc wrap[%0d] act=%b req=%b", k, wrap, e.wrap); end
    end
    pause = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL pause count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (dp !== e.dp) begin bad++; $display("FAIL pause dp[%0d] act=%b req=%b", k, dp, e.dp); end
      total++; if (digit_sel !== e.sel) begin bad++; $display("FAIL pause digit_sel[%0d] act=%b req=%b", k, digit_sel, e.sel); end
    end
    pause = 1'b0; ena = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL freeze count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (digit_sel !== e.sel) begin bad++; $display("FAIL freeze digit_sel[%0d] act=%b req=%b", k, digit_sel, e.sel); end
      total++; if (segments !== e.seg) begin bad++; $display("FAIL freeze segments[%0d] act=%h req=%h", k, segments, e.seg); end
      total++; if (dp !== e.dp) begin bad++; $display("FAIL freeze dp[%0d] act=%b req=%b", k, dp, e.dp); end
    end
    ena = 1'b1;
  endtask

  task automatic test_scan();
    tick_div = '1; pause = 1'b0; up_down = 1'b1; load = 1'b1; load_val = 16'h1234;
    step();
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      total++; if (digit_sel !== e.sel) begin bad++; $display("FAIL scan digit_sel[%0d] act=%b req=%b", k, digit_sel, e.sel); end
      total++; if (segments !== e.seg) begin bad++; $display("FAIL scan segments[%0d] act=%h req=%h", k, segments, e.seg); end
      total++; if (dp !== e.dp) begin bad++; $display("FAIL scan dp[%0d] act=%b req=%b", k, dp, e.dp); end
      total++; if (h_digit_sel !== e.sel) begin bad++; $display("FAIL scan h_digit_sel[%0d] act=%b req=%b", k, h_digit_sel, e.sel); end
      total++; if (h_segments !== e.hseg) begin bad++; $display("FAIL scan h_segments[%0d] act=%h req=%h", k, h_segments, e.hseg); end
      total++; if (h_dp !== e.dp) begin bad++; $display("FAIL scan h_dp[%0d] act=%b req=%b", k, h_dp, e.dp); end
      total++; if (count !== 16'h1234) begin bad++; $display("FAIL scan count[%0d] act=%h req=1234", k, count); end
    end
  endtask

  task automatic test_leading_zero();
    tick_div = '1; load = 1'b1; load_val = 16'h0007;
    step();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (segments !== e.seg) begin bad++; $display("FAIL lzb segments[%0d] act=%h req=%h", k, segments, e.seg); end
      total++; if (h_segments !== e.hseg) begin bad++; $display("FAIL lzb h_segments[%0d] act=%h req=%h", k, h_segments, e.hseg); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    vals[0] = 16'h1A2F; vals[1] = 16'h0000; vals[2] = 16'hFFFF; vals[3] = 16'h4321;
    tick_div = '0; up_down = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load = (k < 4); load_val = (k < 4) ? vals[k] : 16'h0000;
      step();
      total++; if (count !== e.count) begin bad++; $display("FAIL b2b count[%0d] act=%h req=%h", k, count, e.count); end
      total++; if (h_count !== e.hcount) begin bad++; $display("FAIL b2b h_count[%0d] act=%h req=%h", k, h_count, e.hcount); end
      total++; if (wrap !== e.wrap) begin bad++; $display("FAIL b2b wrap[%0d] act=%b req=%b", k, wrap, e.wrap); end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decimal_carry();
    test_up_wrap();
    test_down_wrap();
    test_prescaler_pause();
    test_scan();
    test_leading_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
